data_bus_seq: RTL and testbench

//  Command sequencer that sits directly upstream of the data bus machine.

---
 rtl/data_bus_seq_if.sv | 47 ++++
 rtl/data_bus_seq.sv | 133 +++++++++++++
 tb/tb_data_bus_seq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_seq_if.sv
// Signal bundle joining the core command port, the response port and the data bus machine.
// The sequencer uses the slave view; whatever drives commands and models the bus machine uses master.
interface data_bus_seq_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_rd;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_rd;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_rdata;

    logic              mach_go;
    logic              mach_read_cycle;
    logic [ADDR_W-1:0] mach_addr;
    logic [DATA_W-1:0] mach_wdata;
    logic [DATA_W-1:0] mach_rdata;
    logic              mach_done;
    logic              bus_grant;

    logic              busy;
    logic [LVL_W-1:0]  q_level;

    modport slave (
        input  cmd_valid, cmd_rd, cmd_addr, cmd_wdata,
        input  mach_rdata, mach_done, bus_grant,
        output cmd_ready, rsp_valid, rsp_rd, rsp_err, rsp_rdata,
        output mach_go, mach_read_cycle, mach_addr, mach_wdata,
        output busy, q_level
    );

    modport master (
        output cmd_valid, cmd_rd, cmd_addr, cmd_wdata,
        output mach_rdata, mach_done, bus_grant,
        input  cmd_ready, rsp_valid, rsp_rd, rsp_err, rsp_rdata,
        input  mach_go, mach_read_cycle, mach_addr, mach_wdata,
        input  busy, q_level
    );
endinterface

// File: rtl/data_bus_seq.sv
// Command sequencer ahead of the data bus machine: queues read/write commands, issues them
// one at a time, waits for grant (with timeout) and completion, and returns a one-cycle response.
module data_bus_seq #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input logic           clk,
    input logic           reset_n,
    data_bus_seq_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } state_t;

    typedef struct packed {
        logic              rd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    entry_t           fifo_mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    state_t           state;
    logic [TMO_W-1:0] tmo_cnt;
    logic             push;
    logic             pop;

    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign pop           = (state == IDLE) && (level != '0);
    assign head          = fifo_mem[rd_ptr];
    assign bus.cmd_ready = (level != FULL_LVL);
    assign bus.q_level   = level;
    assign bus.busy      = (state != IDLE) || (level != '0);

    // Storage carries no reset; only the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{rd: bus.cmd_rd, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Response outputs default low every edge so each completion is a single-cycle pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            tmo_cnt             <= '0;
            bus.mach_go         <= 1'b0;
            bus.mach_read_cycle <= 1'b0;
            bus.mach_addr       <= '0;
            bus.mach_wdata      <= '0;
            bus.rsp_valid       <= 1'b0;
            bus.rsp_rd          <= 1'b0;
            bus.rsp_err         <= 1'b0;
            bus.rsp_rdata       <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rd    <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        bus.mach_read_cycle <= head.rd;
                        bus.mach_addr       <= head.addr;
                        bus.mach_wdata      <= head.wdata;
                        bus.mach_go         <= 1'b1;
                        tmo_cnt             <= '0;
                        state               <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.bus_grant) begin
                        bus.mach_go <= 1'b0;
                        state       <= WAIT_DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        bus.mach_go   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rd    <= bus.mach_read_cycle;
                        state         <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (bus.mach_done) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rd    <= bus.mach_read_cycle;
                        bus.rsp_rdata <= bus.mach_read_cycle ? bus.mach_rdata : '0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.mach_go <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_bus_seq.sv
// Directed bench for data_bus_seq: inputs change and outputs are sampled on the falling edge,
// with the bus machine's grant/done timing driven step by step from the main sequence.
module tb_data_bus_seq;
    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int DEPTH       = 4;
    localparam int TIMEOUT_CYC = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   passed  = 0;
    int   failed  = 0;

    data_bus_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    data_bus_seq #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH(DEPTH),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic rd, input logic [15:0] addr, input logic [15:0] wdata);
        bus.cmd_valid = valid;
        bus.cmd_rd    = rd;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
    endtask

    task automatic pushCmd(input string tag, input logic rd, input logic [15:0] addr, input logic [15:0] wdata);
        checkOutput($sformatf("%s_ready", tag), bus.cmd_ready, 1);
        applyStimulus(1'b1, rd, addr, wdata);
        @(negedge clk);
    endtask

    // Plays the bus machine for one command: grant after grant_delay no-grant edges, done 3 (read)
    // or 4 (write) edges after the grant edge, then checks the response pulse.
    task automatic serveCommand(input string tag, input logic exp_rd, input logic [15:0] exp_addr,
                                input logic [15:0] exp_wdata, input logic [15:0] rdata, input int grant_delay);
        int waited;
        waited = 0;
        while (bus.mach_go !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checkOutput($sformatf("%s_go_rise", tag), bus.mach_go, 1);
        checkOutput($sformatf("%s_addr", tag), bus.mach_addr, exp_addr);
        checkOutput($sformatf("%s_read_cycle", tag), bus.mach_read_cycle, exp_rd);
        if (!exp_rd) checkOutput($sformatf("%s_wdata", tag), bus.mach_wdata, exp_wdata);
        bus.bus_grant = (grant_delay == 0);
        for (int i = 0; i < grant_delay; i++) begin
            @(negedge clk);
            checkOutput($sformatf("%s_go_held%0d", tag, i), bus.mach_go, 1);
            if (!exp_rd) checkOutput($sformatf("%s_wdata_held%0d", tag, i), bus.mach_wdata, exp_wdata);
        end
        bus.bus_grant = 1'b1;
        @(negedge clk);
        checkOutput($sformatf("%s_go_drop", tag), bus.mach_go, 0);
        repeat (exp_rd ? 3 : 4) @(negedge clk);
        checkOutput($sformatf("%s_no_early_rsp", tag), bus.rsp_valid, 0);
        bus.mach_done  = 1'b1;
        bus.mach_rdata = rdata;
        @(negedge clk);
        bus.mach_done  = 1'b0;
        bus.mach_rdata = 16'h0000;
        checkOutput($sformatf("%s_rsp_valid", tag), bus.rsp_valid, 1);
        checkOutput($sformatf("%s_rsp_rd", tag), bus.rsp_rd, exp_rd);
        checkOutput($sformatf("%s_rsp_err", tag), bus.rsp_err, 0);
        checkOutput($sformatf("%s_rsp_rdata", tag), bus.rsp_rdata, exp_rd ? rdata : 16'h0000);
        @(negedge clk);
        checkOutput($sformatf("%s_rsp_drop", tag), bus.rsp_valid, 0);
        checkOutput($sformatf("%s_rdata_clear", tag), bus.rsp_rdata, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        bus.mach_rdata = 16'h0000;
        bus.mach_done  = 1'b0;
        bus.bus_grant  = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("rst_go", bus.mach_go, 0);
        checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
        checkOutput("rst_q_level", bus.q_level, 0);
        checkOutput("rst_cmd_ready", bus.cmd_ready, 1);
        checkOutput("rst_busy", bus.busy, 0);
        reset_n = 1'b1;

        // Single read, grant tied high
        bus.bus_grant = 1'b1;
        pushCmd("rd1", 1'b1, 16'h0123, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        checkOutput("rd1_q_level", bus.q_level, 1);
        checkOutput("rd1_go_before_pop", bus.mach_go, 0);
        serveCommand("rd1", 1'b1, 16'h0123, 16'h0000, 16'hBEEF, 0);
        checkOutput("rd1_idle_busy", bus.busy, 0);

        // Write with grant held off for 6 edges
        pushCmd("wr1", 1'b0, 16'h0040, 16'h5A5A);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        serveCommand("wr1", 1'b0, 16'h0040, 16'h5A5A, 16'hDEAD, 6);

        // Five back-to-back pushes with grant low: queue fills, then drains in order
        bus.bus_grant = 1'b0;
        pushCmd("q1", 1'b0, 16'h0100, 16'h1111);
        pushCmd("q2", 1'b1, 16'h0200, 16'h0000);
        pushCmd("q3", 1'b0, 16'h0300, 16'h3333);
        pushCmd("q4", 1'b1, 16'h0400, 16'h0000);
        pushCmd("q5", 1'b0, 16'h0500, 16'h5555);
        applyStimulus(1'b1, 1'b1, 16'h0600, 16'h0000);
        checkOutput("full_q_level", bus.q_level, 4);
        checkOutput("full_cmd_ready", bus.cmd_ready, 0);
        checkOutput("full_busy", bus.busy, 1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        checkOutput("full_no_push", bus.q_level, 4);
        serveCommand("q1", 1'b0, 16'h0100, 16'h1111, 16'hF00D, 0);
        checkOutput("q1_after_pop_level", bus.q_level, 3);
        checkOutput("q1_after_pop_ready", bus.cmd_ready, 1);
        serveCommand("q2", 1'b1, 16'h0200, 16'h0000, 16'h2222, 0);
        serveCommand("q3", 1'b0, 16'h0300, 16'h3333, 16'hAAAA, 0);
        serveCommand("q4", 1'b1, 16'h0400, 16'h0000, 16'h4444, 0);
        serveCommand("q5", 1'b0, 16'h0500, 16'h5555, 16'hBBBB, 0);
        checkOutput("q_drained_level", bus.q_level, 0);
        checkOutput("q_drained_busy", bus.busy, 0);

        // Grant timeout after 8 no-grant edges, then the queued write issues
        bus.bus_grant = 1'b0;
        pushCmd("to_a", 1'b1, 16'h0777, 16'h0000);
        pushCmd("to_b", 1'b0, 16'h0888, 16'h1234);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        checkOutput("to_go_rise", bus.mach_go, 1);
        checkOutput("to_addr", bus.mach_addr, 16'h0777);
        checkOutput("to_q_level", bus.q_level, 1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checkOutput($sformatf("to_go_held%0d", i), bus.mach_go, 1);
            checkOutput($sformatf("to_no_rsp%0d", i), bus.rsp_valid, 0);
        end
        @(negedge clk);
        checkOutput("to_go_drop", bus.mach_go, 0);
        checkOutput("to_rsp_valid", bus.rsp_valid, 1);
        checkOutput("to_rsp_err", bus.rsp_err, 1);
        checkOutput("to_rsp_rd", bus.rsp_rd, 1);
        checkOutput("to_rsp_rdata", bus.rsp_rdata, 0);
        @(negedge clk);
        checkOutput("to_rsp_drop", bus.rsp_valid, 0);
        checkOutput("to_err_drop", bus.rsp_err, 0);
        checkOutput("to_next_go", bus.mach_go, 1);
        checkOutput("to_next_addr", bus.mach_addr, 16'h0888);
        serveCommand("to_b", 1'b0, 16'h0888, 16'h1234, 16'h9999, 0);

        // Spurious done in IDLE and ISSUE; simultaneous push and pop
        bus.bus_grant = 1'b0;
        bus.mach_done = 1'b1;
        @(negedge clk);
        bus.mach_done = 1'b0;
        checkOutput("sp_idle_no_rsp", bus.rsp_valid, 0);
        checkOutput("sp_idle_busy", bus.busy, 0);
        pushCmd("sp_d1", 1'b1, 16'h0A0A, 16'h0000);
        checkOutput("sp_level_before", bus.q_level, 1);
        pushCmd("sp_d2", 1'b0, 16'h0B0B, 16'hCAFE);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        checkOutput("sp_level_pushpop", bus.q_level, 1);
        checkOutput("sp_go", bus.mach_go, 1);
        bus.mach_done  = 1'b1;
        bus.mach_rdata = 16'h1357;
        @(negedge clk);
        bus.mach_done  = 1'b0;
        bus.mach_rdata = 16'h0000;
        checkOutput("sp_issue_no_rsp", bus.rsp_valid, 0);
        checkOutput("sp_issue_go", bus.mach_go, 1);
        serveCommand("sp_d1", 1'b1, 16'h0A0A, 16'h0000, 16'h7E57, 0);
        serveCommand("sp_d2", 1'b0, 16'h0B0B, 16'hCAFE, 16'h2468, 2);

        // Asynchronous reset in the middle of an issue
        bus.bus_grant = 1'b0;
        pushCmd("mr_1", 1'b1, 16'h0F00, 16'h0000);
        pushCmd("mr_2", 1'b0, 16'h0F01, 16'hAAAA);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        checkOutput("mr_go_before", bus.mach_go, 1);
        checkOutput("mr_level_before", bus.q_level, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("mr_go", bus.mach_go, 0);
        checkOutput("mr_rsp_valid", bus.rsp_valid, 0);
        checkOutput("mr_q_level", bus.q_level, 0);
        checkOutput("mr_cmd_ready", bus.cmd_ready, 1);
        checkOutput("mr_addr", bus.mach_addr, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("mr_post_go", bus.mach_go, 0);
        checkOutput("mr_post_busy", bus.busy, 0);

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
